// File: rtl/multi_flicker.sv
// Multi-channel candle-flicker LED driver: shared prescaler and Galois LFSR feed
// per-channel smoothed levels, each driving a registered PWM output.
// Optional MULTI_FLICKER_STAGGER_EN staggers PWM phases across channels.
module multi_flicker #(
  parameter int          CHANNELS  = 4,
  parameter int          PWM_BITS  = 8,
  parameter int          FLKR_DIV  = 122,
  parameter int          LFSR_DIV  = 4,
  parameter int          STEP      = 4,
  parameter int          MIN_LEVEL = 64,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS-1:0]          ch_en,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [CHANNELS*PWM_BITS-1:0] level_o
);

  localparam int PW = (FLKR_DIV > 1) ? $clog2(FLKR_DIV) : 1;
  localparam int LW = (LFSR_DIV > 1) ? $clog2(LFSR_DIV) : 1;
  localparam int EW = PWM_BITS + 1;
  localparam logic [15:0]         SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [PWM_BITS-1:0] LOW_ONES  = PWM_BITS'((2 ** (PWM_BITS - 4)) - 1);
  localparam logic [PWM_BITS-1:0] MIN_LVL   = PWM_BITS'(MIN_LEVEL);
  localparam logic [PWM_BITS-1:0] ALL_ONES  = '1;
  localparam logic [EW-1:0]       STEP_N    = EW'(STEP);
  localparam logic [EW-1:0]       STEP_G    = EW'(2 * STEP);
  localparam int                  PHASE_INC = (2 ** PWM_BITS) / CHANNELS;

  localparam logic [1:0] M_FLICKER = 2'b00;
  localparam logic [1:0] M_STEADY  = 2'b01;
  localparam logic [1:0] M_GUST    = 2'b10;
  localparam logic [1:0] M_HOLD    = 2'b11;

  logic [PW-1:0]       presc_q, presc_d;
  logic [LW-1:0]       lstep_q, lstep_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0] level_q, level_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0] target;
  logic [CHANNELS-1:0][PWM_BITS-1:0] pc;

  logic          flkr_tick;
  logic          lfsr_adv;
  logic [15:0]   lfsr_nx;
  logic [3:0]    nib;
  logic [PWM_BITS-1:0] raw;
  logic [EW-1:0] step_amt;
  logic [EW-1:0] lvl_ext;
  logic [EW-1:0] tgt_ext;
  logic [EW-1:0] up_val;
  logic [EW-1:0] dn_val;

  always_comb begin
    flkr_tick = (presc_q == PW'(FLKR_DIV - 1));
    presc_d   = flkr_tick ? '0 : presc_q + PW'(1);

    lstep_d = lstep_q;
    if (flkr_tick) begin
      lstep_d = (lstep_q == LW'(LFSR_DIV - 1)) ? '0 : lstep_q + LW'(1);
    end

    lfsr_adv = flkr_tick &&
               (((mode == M_FLICKER) && (lstep_q == LW'(LFSR_DIV - 1))) || (mode == M_GUST));
    lfsr_nx  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    lfsr_d   = lfsr_adv ? lfsr_nx : lfsr_q;

    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    step_amt  = (mode == M_GUST) ? STEP_G : STEP_N;
  end

  // Per-channel target, smoothing, phase and duty shadow.
  always_comb begin
    nib       = '0;
    raw       = '0;
    lvl_ext   = '0;
    tgt_ext   = '0;
    up_val    = '0;
    dn_val    = '0;
    target    = '0;
    pc        = '0;
    level_d   = level_q;
    duty_d    = duty_q;
    pwm_out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      for (int j = 0; j < 4; j++) begin
        nib[j] = lfsr_q[(4 * i + j) % 16];
      end
      raw = (PWM_BITS'(nib) << (PWM_BITS - 4)) | LOW_ONES;
      if (mode == M_STEADY) begin
        target[i] = ALL_ONES;
      end else begin
        target[i] = (raw < MIN_LVL) ? MIN_LVL : raw;
      end

      // One extra bit of headroom keeps level+step from wrapping.
      lvl_ext = {1'b0, level_q[i]};
      tgt_ext = {1'b0, target[i]};
      up_val  = lvl_ext + step_amt;
      if (up_val > tgt_ext) up_val = tgt_ext;
      dn_val  = ((lvl_ext - tgt_ext) > step_amt) ? (lvl_ext - step_amt) : tgt_ext;
      if (flkr_tick && (mode != M_HOLD)) begin
        if (lvl_ext < tgt_ext) begin
          level_d[i] = up_val[PWM_BITS-1:0];
        end else if (lvl_ext > tgt_ext) begin
          level_d[i] = dn_val[PWM_BITS-1:0];
        end
      end

`ifdef MULTI_FLICKER_STAGGER_EN
      pc[i] = pwm_cnt_q + PWM_BITS'(i * PHASE_INC);
`else
      pc[i] = pwm_cnt_q;
`endif
      // Duty reloads from the pre-update level at the end of each period.
      if (pc[i] == ALL_ONES) duty_d[i] = level_q[i];
      pwm_out_d[i] = ch_en[i] & (pc[i] < duty_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      lstep_q   <= '0;
      lfsr_q    <= SEED_EFF;
      pwm_cnt_q <= '0;
      level_q   <= '0;
      duty_q    <= '0;
      pwm_out_q <= '0;
    end else begin
      presc_q   <= presc_d;
      lstep_q   <= lstep_d;
      lfsr_q    <= lfsr_d;
      pwm_cnt_q <= pwm_cnt_d;
      level_q   <= level_d;
      duty_q    <= duty_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;
  assign level_o = level_q;

endmodule

// File: doc/multi_flicker.md
Name: multi_flicker

Overview:
- Multi-channel candle-flicker LED driver; successor to the single-channel counter/LFSR/flicker/PWM chain.
- One shared prescaler and one 16-bit LFSR feed CHANNELS independent smoothed brightness levels, each driving its own PWM output.
- Adds per-channel enable, global operating modes (flicker/steady/gust/hold) and glitch-free duty updates.
- Sits directly behind the pad-level top, clocked from io_in[0].

Parameters:
- CHANNELS, 4, number of LED outputs (1..16).
- PWM_BITS, 8, PWM and brightness resolution (>=4).
- FLKR_DIV, 122, clk cycles per flicker tick (>=1).
- LFSR_DIV, 4, flicker ticks per LFSR step in flicker mode (>=1).
- STEP, 4, maximum level change per flicker tick (>=1).
- MIN_LEVEL, 64, floor of any flicker target.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  2  00 flicker, 01 steady, 10 gust, 11 hold.
- ch_en  in  CHANNELS  per-channel output enable.
- pwm_out  out  CHANNELS  registered PWM drive, one bit per channel.
- level_o  out  CHANNELS*PWM_BITS  current smoothed level; channel i occupies bits [i*PWM_BITS +: PWM_BITS].

Behaviour:
- Reset (rst low, async): prescaler, LFSR-step counter, pwm_cnt, all levels, duty shadows and pwm_out go to 0; LFSR goes to SEED. Takes effect immediately, including mid-PWM-period.
- Prescaler: counts 0..FLKR_DIV-1 and wraps. flkr_tick is high for exactly the one cycle in which count==FLKR_DIV-1. With FLKR_DIV=1, flkr_tick is high every cycle.
- LFSR step counter: 0..LFSR_DIV-1, advances on flkr_tick.
  - LFSR steps on a flkr_tick where the counter wraps (mode 00).
  - LFSR steps on every flkr_tick (mode 10).
  - LFSR never steps in modes 01 and 11.
- LFSR: Galois, right shift. next = (l>>1) ^ (l[0] ? 16'hB400 : 0). Never reaches 0.
- Channel nibble: nib_i bit j = lfsr[(4i+j) mod 16].
- Target:
  - Modes 00/10: target_i = max(MIN_LEVEL, {nib_i, (PWM_BITS-4) ones}).
  - Mode 01: target_i = all ones.
- Smoothing, evaluated on flkr_tick only:
  - Effective step = STEP in modes 00/01, 2*STEP in mode 10.
  - level<target: level = min(level+step, target).
  - level>target: level = max(level-step, target).
  - Arithmetic is done in PWM_BITS+1 bits; no wrap, no overshoot.
  - Mode 11: level frozen.
  - A mode change is sampled on the next flkr_tick.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter, +1 every cycle, wraps.
  - duty_i loads level_i in the cycle pwm_cnt==all ones, so a duty change starts at the next period boundary.
  - pwm_out_i is registered: pwm_out_i <= ch_en_i & (pwm_cnt < duty_i).
  - Duty 0 gives constant 0; duty all-ones gives (2^PWM_BITS-1)/2^PWM_BITS high.
- ch_en_i low forces pwm_out_i to 0 on the next edge; the level keeps evolving. Re-enabling resumes at the current duty with no restart.
- Simultaneous events: a flkr_tick that coincides with the duty-load cycle loads the pre-update level; the new level is loaded one period later.

Optional Feature:
- Macro: MULTI_FLICKER_STAGGER_EN.
- Defined:
  - Channel i compares against pc_i = pwm_cnt + i*(2^PWM_BITS/CHANNELS), taken mod 2^PWM_BITS.
  - duty_i loads when pc_i==all ones.
  - Rising edges are staggered across channels, which reduces peak supply current.
- Undefined: all channels share pwm_cnt phase and edges are aligned.

Test Plan:
- Reset: run 5000 cycles, pull rst low mid-period -> pwm_out=0 and level_o=0 in the same cycle, LFSR=16'hACE1; hold 3 cycles, release -> prescaler restarts from 0.
- Prescaler/LFSR, defaults, mode=00: first flkr_tick on the 122nd clock after release. LFSR changes only on the 4th tick, to 16'hE270. Check nib_0=4'h0 gives target 64, and nib_i for all channels against the bit mapping.
- Steady, mode=01 from reset: level_o of every channel rises 4 per tick and reaches 255 after 64 ticks (252+4 clipped), then stays there. pwm_out_i is high 255 of every 256 cycles; the duty change is seen only at pwm_cnt wrap.
- Gust versus hold:
  - mode=10 -> LFSR steps every tick and levels move by up to 8 per tick.
  - Switch to 11 -> level_o and LFSR unchanged over 2000 cycles.
- Smoothing clamp, FLKR_DIV=1 build: force level 62 toward target 64 -> next level 64 (not 66). level 66 toward target 64 -> next level 64.
- ch_en: drop ch_en[2] -> pwm_out[2]=0 on the next edge while level_o[2] still tracks. Other channels unaffected. With MULTI_FLICKER_STAGGER_EN and all duties 128, rising edges are spaced 64 cycles apart.
